// File: rtl/corr_search_seq_pkg.sv
// Shared types and default widths for the correlation search engine family.
package corr_search_seq_pkg;

    // Score must hold values 0..WIDTH inclusive
    function automatic int unsigned score_w_for(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned N_CAND_DEF  = 16;
    localparam int unsigned IDX_W_DEF   = $clog2(N_CAND_DEF);
    localparam int unsigned SCORE_W_DEF = score_w_for(WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/corr_search_seq_match_score.sv
// Combinational equal-bit popcount between a candidate word and the target.
module match_score
    import corr_search_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SCORE_W = SCORE_W_DEF
) (
    input  logic [WIDTH-1:0]   Num,
    input  logic [WIDTH-1:0]   Target,
    output logic [SCORE_W-1:0] Score_c
);

    logic [WIDTH-1:0] eq_bits;

    assign eq_bits = ~(Num ^ Target);

    // Count positions where candidate and target agree
    always_comb begin
        Score_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            Score_c = Score_c + SCORE_W'(eq_bits[i]);
        end
    end

endmodule

// File: rtl/corr_search_seq.sv
// Sequential best-match search: one shared scorer, one candidate per accepted beat.
module corr_search_seq
    import corr_search_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned N_CAND     = N_CAND_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned SCORE_W    = SCORE_W_DEF,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [WIDTH-1:0]   Target_Num,
    input  logic               Cand_Valid,
    input  logic [WIDTH-1:0]   Cand_Data,
    output logic               Cand_Ready,
    output logic               Busy,
    output logic               Done,
    output logic [IDX_W-1:0]   Best_Idx,
    output logic [SCORE_W-1:0] Best_Score,
    output logic               Exact_Hit
);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CAND - 1);
    localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   target;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   run_idx;
    logic [SCORE_W-1:0] run_score;

    logic [SCORE_W-1:0] score_c;
    logic               upd_c;
    logic               exact_c;
    logic               finish_c;
    logic [IDX_W-1:0]   nxt_idx_c;
    logic [SCORE_W-1:0] nxt_score_c;

    match_score #(
        .WIDTH   (WIDTH),
        .SCORE_W (SCORE_W)
    ) u_score (
        .Num     (Cand_Data),
        .Target  (target),
        .Score_c (score_c)
    );

    // Running-best candidate after this beat; strict compare keeps the lowest index on ties
    always_comb begin
        upd_c       = (cnt == '0) || (score_c > run_score);
        exact_c     = (score_c == FULL_SCORE);
        finish_c    = (cnt == LAST_IDX) || (EARLY_EXIT && exact_c);
        nxt_idx_c   = upd_c ? cnt     : run_idx;
        nxt_score_c = upd_c ? score_c : run_score;
    end

    // Controller FSM, beat counter, best tracking and published results
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            target     <= '0;
            cnt        <= '0;
            run_idx    <= '0;
            run_score  <= '0;
            Cand_Ready <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Best_Idx   <= '0;
            Best_Score <= '0;
            Exact_Hit  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        target     <= Target_Num;
                        cnt        <= '0;
                        run_idx    <= '0;
                        run_score  <= '0;
                        Cand_Ready <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (Abort) begin
                        // Beat in the same cycle is dropped; published results stay untouched
                        Cand_Ready <= 1'b0;
                        Busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (Cand_Valid) begin
                        run_idx   <= nxt_idx_c;
                        run_score <= nxt_score_c;
                        cnt       <= cnt + IDX_W'(1);
                        if (finish_c) begin
                            Cand_Ready <= 1'b0;
                            Busy       <= 1'b0;
                            Done       <= 1'b1;
                            Best_Idx   <= nxt_idx_c;
                            Best_Score <= nxt_score_c;
                            Exact_Hit  <= (nxt_score_c == FULL_SCORE);
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    Cand_Ready <= 1'b0;
                    Busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_search_seq.sv
// Directed bench for corr_search_seq: streaming, ties, backpressure, early exit, abort, reset.
module tb_corr_search_seq;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Start_EE;
    logic        Abort;
    logic [31:0] Target_Num;
    logic        Cand_Valid;
    logic [31:0] Cand_Data;

    logic        Cand_Ready, Busy, Done, Exact_Hit;
    logic [3:0]  Best_Idx;
    logic [5:0]  Best_Score;

    logic        Cand_Ready_EE, Busy_EE, Done_EE, Exact_Hit_EE;
    logic [3:0]  Best_Idx_EE;
    logic [5:0]  Best_Score_EE;

    logic [31:0] cands [16];
    int          tests_run;
    int          tests_failed;

    corr_search_seq dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Abort      (Abort),
        .Target_Num (Target_Num),
        .Cand_Valid (Cand_Valid),
        .Cand_Data  (Cand_Data),
        .Cand_Ready (Cand_Ready),
        .Busy       (Busy),
        .Done       (Done),
        .Best_Idx   (Best_Idx),
        .Best_Score (Best_Score),
        .Exact_Hit  (Exact_Hit)
    );

    corr_search_seq #(.EARLY_EXIT(1'b1)) dut_ee (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start_EE),
        .Abort      (Abort),
        .Target_Num (Target_Num),
        .Cand_Valid (Cand_Valid),
        .Cand_Data  (Cand_Data),
        .Cand_Ready (Cand_Ready_EE),
        .Busy       (Busy_EE),
        .Done       (Done_EE),
        .Best_Idx   (Best_Idx_EE),
        .Best_Score (Best_Score_EE),
        .Exact_Hit  (Exact_Hit_EE)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Candidate 5 equals 0xFFFF0000, all others are its complement
    task automatic load_exact();
        for (int i = 0; i < 16; i++) cands[i] = (i == 5) ? 32'hFFFF0000 : 32'h0000FFFF;
    endtask

    // Against target 0, candidate i scores exactly i
    task automatic load_incr();
        for (int i = 0; i < 16; i++) cands[i] = 32'hFFFFFFFF >> i;
    endtask

    // Start a search at cycle 0 and stream cands; reports the cycle Done was seen and the results
    task automatic run_search(input logic [31:0] tgt, input bit bp, input bit ee, input int inj_cyc,
                              output int done_cyc, output logic [3:0] idx, output logic [5:0] sc,
                              output logic hit);
        int   beat;
        logic d, rdy;
        beat = 0; done_cyc = -1; idx = '0; sc = '0; hit = 1'b0;
        @(posedge Clock); #1;
        Target_Num = tgt;
        if (ee) Start_EE = 1'b1; else Start = 1'b1;
        for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
            @(posedge Clock); #1;
            Start = 1'b0; Start_EE = 1'b0;
            if (c == inj_cyc) begin
                Start      = 1'b1;
                Target_Num = 32'h0;
            end
            Cand_Valid = (!bp || (c % 2 == 1)) && (beat < 16);
            Cand_Data  = Cand_Valid ? cands[beat] : $urandom();
            @(negedge Clock);
            d   = ee ? Done_EE : Done;
            rdy = ee ? Cand_Ready_EE : Cand_Ready;
            if (d) begin
                done_cyc = c;
                idx = ee ? Best_Idx_EE : Best_Idx;
                sc  = ee ? Best_Score_EE : Best_Score;
                hit = ee ? Exact_Hit_EE : Exact_Hit;
            end else if (Cand_Valid && rdy) begin
                beat++;
            end
        end
        @(posedge Clock); #1;
        Cand_Valid = 1'b0; Start = 1'b0;
        if (done_cyc < 0) begin
            tests_run++; tests_failed++;
            $display("FAIL timeout: no Done within 80 cycles");
        end
    endtask

    task automatic check_result(input string name, input int dc, input logic [3:0] idx,
                                input logic [5:0] sc, input logic hit, input int exp_dc,
                                input logic [3:0] exp_idx, input logic [5:0] exp_sc, input logic exp_hit);
        tests_run++;
        if (dc !== exp_dc) begin
            tests_failed++; $display("FAIL %s done_cycle: got %0d expected %0d", name, dc, exp_dc);
        end
        tests_run++;
        if (idx !== exp_idx) begin
            tests_failed++; $display("FAIL %s Best_Idx: got %0d expected %0d", name, idx, exp_idx);
        end
        tests_run++;
        if (sc !== exp_sc) begin
            tests_failed++; $display("FAIL %s Best_Score: got %0d expected %0d", name, sc, exp_sc);
        end
        tests_run++;
        if (hit !== exp_hit) begin
            tests_failed++; $display("FAIL %s Exact_Hit: got %0b expected %0b", name, hit, exp_hit);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Start_EE = 1'b0; Abort = 1'b0;
        Target_Num = '0; Cand_Valid = 1'b0; Cand_Data = '0;
        repeat (2) @(negedge Clock);
        tests_run++;
        if ({Cand_Ready, Busy, Done, Best_Idx, Best_Score, Exact_Hit} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {Cand_Ready, Busy, Done, Best_Idx, Best_Score, Exact_Hit});
        end
        Reset = 1'b1;
        @(negedge Clock);
        tests_run++;
        if ({Cand_Ready, Busy, Done} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_idle: got %b expected 000", {Cand_Ready, Busy, Done});
        end
    endtask

    task automatic test_exact_stream();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        load_exact();
        run_search(32'hFFFF0000, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("exact_stream", dc, i, s, h, 17, 4'd5, 6'd32, 1'b1);
    endtask

    task automatic test_ties();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        for (int k = 0; k < 16; k++) cands[k] = 32'h0000FFFF;
        run_search(32'hFFFFFFFF, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("ties", dc, i, s, h, 17, 4'd0, 6'd16, 1'b0);
    endtask

    task automatic test_last_beat_wins();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        load_incr();
        run_search(32'h0, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("last_beat", dc, i, s, h, 17, 4'd15, 6'd15, 1'b0);
    endtask

    task automatic test_backpressure();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        load_exact();
        run_search(32'hFFFF0000, 1'b1, 1'b0, -1, dc, i, s, h);
        check_result("backpressure", dc, i, s, h, 32, 4'd5, 6'd32, 1'b1);
    endtask

    task automatic test_early_exit();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        load_exact();
        run_search(32'hFFFF0000, 1'b0, 1'b1, -1, dc, i, s, h);
        check_result("early_exit", dc, i, s, h, 7, 4'd5, 6'd32, 1'b1);
    endtask

    task automatic test_abort();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        int beat; bit aborted; bit saw_done;
        load_exact();
        run_search(32'hFFFF0000, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("abort_pre", dc, i, s, h, 17, 4'd5, 6'd32, 1'b1);
        load_incr();
        beat = 0; aborted = 1'b0; saw_done = 1'b0;
        @(posedge Clock); #1;
        Target_Num = 32'h0; Start = 1'b1;
        for (int c = 1; c <= 40 && !aborted; c++) begin
            @(posedge Clock); #1;
            Start = 1'b0; Cand_Valid = 1'b1; Cand_Data = cands[beat];
            Abort = (beat == 7);
            @(negedge Clock);
            if (Done) saw_done = 1'b1;
            if (Abort) aborted = 1'b1;
            else if (Cand_Ready) beat++;
        end
        @(posedge Clock); #1;
        Abort = 1'b0; Cand_Valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            if (Done) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++; $display("FAIL abort_no_done: got Done=1 expected none");
        end
        tests_run++;
        if ({Busy, Cand_Ready} !== 2'b00) begin
            tests_failed++; $display("FAIL abort_idle: got Busy,Ready=%b expected 00", {Busy, Cand_Ready});
        end
        tests_run++;
        if ({Best_Idx, Best_Score, Exact_Hit} !== {4'd5, 6'd32, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_hold: got %0d/%0d/%0b expected 5/32/1", Best_Idx, Best_Score, Exact_Hit);
        end
        run_search(32'h0, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("abort_post", dc, i, s, h, 17, 4'd15, 6'd15, 1'b0);
    endtask

    task automatic test_mid_start();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        load_exact();
        run_search(32'hFFFF0000, 1'b0, 1'b0, 5, dc, i, s, h);
        check_result("mid_start", dc, i, s, h, 17, 4'd5, 6'd32, 1'b1);
    endtask

    task automatic test_reset_mid();
        int dc; logic [3:0] i; logic [5:0] s; logic h;
        int beat; bit hit_reset;
        load_exact();
        beat = 0; hit_reset = 1'b0;
        @(posedge Clock); #1;
        Target_Num = 32'hFFFF0000; Start = 1'b1;
        for (int c = 1; c <= 40 && !hit_reset; c++) begin
            @(posedge Clock); #1;
            Start = 1'b0; Cand_Valid = 1'b1; Cand_Data = cands[beat];
            @(negedge Clock);
            if (beat == 10) begin
                hit_reset = 1'b1;
                tests_run++;
                if (Busy !== 1'b1) begin
                    tests_failed++; $display("FAIL reset_mid_busy: got %0b expected 1", Busy);
                end
                Reset = 1'b0;
                #1;
                tests_run++;
                if ({Cand_Ready, Busy, Done, Best_Idx, Best_Score, Exact_Hit} !== 14'd0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_outputs: got %b expected 0",
                             {Cand_Ready, Busy, Done, Best_Idx, Best_Score, Exact_Hit});
                end
            end else if (Cand_Ready) begin
                beat++;
            end
        end
        Cand_Valid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        run_search(32'hFFFF0000, 1'b0, 1'b0, -1, dc, i, s, h);
        check_result("reset_mid_post", dc, i, s, h, 17, 4'd5, 6'd32, 1'b1);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_exact_stream();
        test_ties();
        test_last_beat_wins();
        test_backpressure();
        test_early_exit();
        test_abort();
        test_mid_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/corr_search_seq.md
Name: corr_search_seq

Overview:
- Sequential best-match search engine. Scores a stream of N_CAND candidate words against a target latched at Start. The score is the count of bit positions where candidate and target are equal.
- Reports the index and score of the best candidate. One shared scoring unit is time-multiplexed over all candidates, one per accepted beat, instead of N parallel scorers.
- Sits between a candidate source with a valid/ready stream and the downstream consumer of the match index.

Parameters:
- WIDTH, 32, candidate/target word width in bits.
- N_CAND, 16, number of candidates per search.
- IDX_W, 4, index width; must equal clog2(N_CAND).
- SCORE_W, 6, score width; must satisfy 2^SCORE_W > WIDTH.
- EARLY_EXIT, 0, if 1, end the search on the first exact match.

Ports:
- Clock, input, 1, single clock; all state on rising edge.
- Reset, input, 1, asynchronous active-low reset.
- Start, input, 1, begin search; sampled in IDLE only.
- Abort, input, 1, cancel search; sampled in SCAN only.
- Target_Num, input, WIDTH, target word; latched on accepted Start.
- Cand_Valid, input, 1, candidate beat valid.
- Cand_Data, input, WIDTH, candidate word.
- Cand_Ready, output, 1, engine accepts a beat (high in SCAN).
- Busy, output, 1, high in SCAN.
- Done, output, 1, one-cycle pulse when a result is published.
- Best_Idx, output, IDX_W, index of best candidate, 0-based in stream order.
- Best_Score, output, SCORE_W, equal-bit count of best candidate.
- Exact_Hit, output, 1, Best_Score == WIDTH.

Behaviour:
- **Reset.** While Reset is low, all outputs are 0, the FSM is in IDLE, and the internal counters and best registers are 0. Reset acts asynchronously, including mid-scan. After release, the engine waits for a new Start.
- **FSM states.** IDLE, SCAN, DONE.
- **IDLE.**
  - Cand_Ready = 0.
  - Start = 1: latch Target_Num; clear beat counter cnt, run_idx and run_score; go to SCAN.
- **SCAN.**
  - Cand_Ready = 1, Busy = 1.
  - A beat is accepted when Cand_Valid = 1. Cand_Data on non-accepted cycles is ignored.
  - Per accepted beat: score = popcount(~(Cand_Data ^ target)), zero-extended to SCORE_W.
  - Update run_idx/run_score when cnt == 0 or score > run_score. Updates are strictly greater, so ties keep the lowest index.
  - Then cnt increments.
  - The last beat (cnt == N_CAND-1) goes to DONE.
  - If EARLY_EXIT = 1 and score == WIDTH, go to DONE immediately with that beat's index.
  - Abort = 1 goes to IDLE. Abort has priority over a beat accepted in the same cycle; that beat is discarded. Published outputs are unchanged and no Done is raised.
  - Start is ignored in SCAN, and Target_Num changes have no effect mid-search.
- **DONE (one cycle).**
  - Done = 1, Busy = 0, Cand_Ready = 0.
  - Best_Idx, Best_Score and Exact_Hit take the run values in the same cycle Done is high.
  - Next state is IDLE. Start in DONE is ignored.
- **Output holding.** Published outputs hold until the next DONE or reset.
- **Latency.** With Start accepted at cycle t and Cand_Valid held high, beats are accepted in cycles t+1..t+N_CAND and Done is high at cycle t+N_CAND+1. Each cycle with Cand_Valid low adds one cycle.
- **Scorer timing.** The scorer is combinational within the accept cycle. Only the registers run_idx, run_score, cnt, target and the state are updated.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/SCAN/DONE);
  - the default widths WIDTH/N_CAND/IDX_W/SCORE_W;
  - the score function width rule.
- One sub-module, **match_score**: purely combinational. It takes (Num, Target) of WIDTH bits and outputs SCORE_W bits, the equal-bit popcount. It is reused by any future parallel variant.
- The controller FSM, counter and best-tracking logic live in corr_search_seq.

Test Plan:
- **Exact match, streaming.** Target = 0xFFFF0000; candidate 5 = 0xFFFF0000; others = 0x0000FFFF (score 0), Valid held high, Start at cycle 0 → Done at cycle 17, Best_Idx = 5, Best_Score = 32, Exact_Hit = 1.
- **Ties.** Target = 0xFFFFFFFF; all 16 candidates = 0x0000FFFF (score 16) → Best_Idx = 0, Best_Score = 16, Exact_Hit = 0.
- **Backpressure.** Same data as the exact-match test with Cand_Valid high every other cycle, and garbage on Cand_Data when Valid is low → Done at cycle 32, Best_Idx = 5; with EARLY_EXIT = 1 and full Valid → Done at cycle 7.
- **Abort.** Complete the exact-match search first (Best_Idx = 5), then Start a second search and assert Abort on its 8th beat → FSM back in IDLE, no Done, outputs still 5/32/1. A following full search then publishes its own result.
- **Mid-search Start and target change.** Start and Target_Num = 0 asserted during SCAN → ignored; the result uses the originally latched target.
- **Reset mid-search.** Drive Reset low at beat 10 → all outputs 0 immediately (asynchronous), Cand_Ready = 0. After release, a new search runs normally from IDLE.
